rggen_external_register: RTL and testbench
==========================================

Name: rggen_external_register

Overview:
- Register-map leaf that forwards host accesses in an address window [START_ADDRESS, END_ADDRESS] to an external slave over a valid/ready bus.
- Successor to the fixed single-register default register: configurable window size, byte-strobe generation, registered request/response handshake and a programmable access timeout.
- Instantiated by the register block next to ordinary registers; the external slave sees window-relative addresses.

Parameters:
- ADDRESS_WIDTH, 16, host/external address width.
- START_ADDRESS, '0, first byte address of the window.
- END_ADDRESS, '0, last byte address of the window (inclusive).
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 0, external wait limit in cycles; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_request  input  1  host access valid; held until o_ready.
- i_address  input  ADDRESS_WIDTH  host byte address.
- i_write  input  1  1 = write, 0 = read.
- i_write_data  input  DATA_WIDTH  write data.
- i_write_mask  input  DATA_WIDTH  per-bit write enable.
- o_select  output  1  combinational: i_request and address inside the window.
- o_ready  output  1  access complete, one-cycle pulse.
- o_status  output  2  response: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.
- o_read_data  output  DATA_WIDTH  read data, valid with o_ready.
- o_ext_valid  output  1  external request valid.
- o_ext_address  output  ADDRESS_WIDTH  i_address minus START_ADDRESS.
- o_ext_write  output  1  external direction.
- o_ext_write_data  output  DATA_WIDTH  external write data.
- o_ext_strobe  output  DATA_WIDTH/8  byte strobes.
- i_ext_ready  input  1  external completion.
- i_ext_status  input  2  external response, same encoding as o_status.
- i_ext_read_data  input  DATA_WIDTH  external read data.

Behaviour:
- Reset values: state IDLE. All registered outputs are 0, including o_ext_*, o_ready, o_status and o_read_data. The timeout counter is 0.
- Window hit: START_ADDRESS <= i_address <= END_ADDRESS. Computed at full ADDRESS_WIDTH with no wrap.
- FSM states:
  - IDLE: when o_select = 1, register the address offset, write, data and strobes; set o_ext_valid = 1; go to BUSY.
  - BUSY: o_ext_valid and all o_ext_* are held stable.
    - If i_ext_ready = 1: capture i_ext_status, and i_ext_read_data on reads (0 on writes); drop o_ext_valid; go to DONE.
    - Else, if TIMEOUT_CYCLES > 0 and the counter equals TIMEOUT_CYCLES-1: abort. Drop o_ext_valid, capture status SLAVE_ERROR and read data 0, go to DONE.
    - Else increment the counter, saturating.
  - DONE: o_ready = 1 for exactly one cycle, with the captured o_status and o_read_data; clear the counter; go to IDLE. o_read_data returns to 0 in the next cycle.
- Latency: request at cycle 0, o_ext_valid at cycle 1. i_ext_ready at cycle N (N >= 1) gives o_ready at cycle N+1. Minimum 2 cycles from request to o_ready.
- Host back-to-back: the host drops or changes i_request in the cycle after o_ready. IDLE relaunches only on o_select, so there is no double launch.
- Strobe: bit k = OR of i_write_mask[8k+7:8k] on writes; all zeros on reads.
- Simultaneous i_ext_ready and timeout expiry in the same cycle: ready wins and its status is used.
- i_ext_ready in IDLE or DONE is ignored.
- After an abort the external slave must tolerate the withdrawn valid. A late i_ext_ready is ignored.
- Reset asserted mid-access: immediate return to IDLE. o_ext_valid and o_ready drop asynchronously; no response is issued.
- Out-of-window request: o_select = 0 and no external access. Decode error is generated by the register block, not here.

Decomposition:
- Shared package rggen_rtl_pkg holds:
  - the rggen_status enum (OKAY, EXOKAY, SLAVE_ERROR, DECODE_ERROR);
  - the direction enum;
  - the function that reduces a bit mask to byte strobes.
- FSM state enum and the counter are local.
- No sub-module: a single module of roughly 150–250 lines.

Test Plan:
- Write 0xDEADBEEF, mask 0x0000FFFF, to START_ADDRESS+4 (START=0x100, END=0x1FF); slave answers ready on the 3rd valid cycle with OKAY -> ext_address 0x004, strobe 0b0011, o_ready 1 cycle later with status 00, request-to-ready = 4 cycles.
- Read at 0x1FC; slave returns 0x12345678 with status EXOKAY on the first valid cycle -> o_read_data 0x12345678 and o_status 01 at cycle 2, strobe 0b0000.
- TIMEOUT_CYCLES=8, slave never ready -> o_ext_valid high for exactly 8 cycles, then o_ready with status 10 and read data 0. A late i_ext_ready is ignored and the FSM stays in IDLE.
- i_ext_ready coincident with the timeout cycle, slave status 00 -> o_status 00.
- Requests at 0x0FF and 0x200 -> o_select 0 and o_ext_valid never asserts.
- rst_n pulsed low while in BUSY -> o_ext_valid 0 immediately, no o_ready pulse. A new request after reset completes normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
//
// Purpose: shared types and helpers for the rggen register-map leaves.
//   - rggen_status_e    : bus response encoding shared by host and external side
//   - rggen_direction_e : access direction encoding
//   - rggen_byte_strobe : reduces one byte of a per-bit write mask to a strobe
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status_e;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction_e;

    // A byte lane is strobed when any bit inside it is write-enabled.
    function automatic logic rggen_byte_strobe(input logic [7:0] mask_byte);
        return |mask_byte;
    endfunction

endpackage

// File: rtl/rggen_external_register.sv
// ---------------------------------------------------------------------------
// rggen_external_register
//
// Purpose: register-map leaf that forwards host accesses falling inside the
// byte window [START_ADDRESS, END_ADDRESS] to an external slave over a
// valid/ready bus, with window-relative addressing, byte-strobe generation,
// a registered request/response handshake and an optional access timeout.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_request            host access valid, held until o_ready
//   i_address            host byte address
//   i_write              1 = write, 0 = read
//   i_write_data         host write data
//   i_write_mask         per-bit write enable
//   o_select             combinational window hit qualified by i_request
//   o_ready              one-cycle completion pulse
//   o_status             response (OKAY/EXOKAY/SLAVE_ERROR/DECODE_ERROR)
//   o_read_data          read data, valid with o_ready
//   o_ext_valid          external request valid
//   o_ext_address        window-relative address
//   o_ext_write          external direction
//   o_ext_write_data     external write data
//   o_ext_strobe         external byte strobes
//   i_ext_ready          external completion
//   i_ext_status         external response
//   i_ext_read_data      external read data
// ---------------------------------------------------------------------------
module rggen_external_register
    import rggen_rtl_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH  = 16,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS  = '0,
    parameter logic [ADDRESS_WIDTH-1:0] END_ADDRESS    = '0,
    parameter int                       DATA_WIDTH     = 32,
    parameter int                       TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_request,
    input  logic [ADDRESS_WIDTH-1:0]   i_address,
    input  logic                       i_write,
    input  logic [DATA_WIDTH-1:0]      i_write_data,
    input  logic [DATA_WIDTH-1:0]      i_write_mask,
    output logic                       o_select,
    output logic                       o_ready,
    output logic [1:0]                 o_status,
    output logic [DATA_WIDTH-1:0]      o_read_data,
    output logic                       o_ext_valid,
    output logic [ADDRESS_WIDTH-1:0]   o_ext_address,
    output logic                       o_ext_write,
    output logic [DATA_WIDTH-1:0]      o_ext_write_data,
    output logic [DATA_WIDTH/8-1:0]    o_ext_strobe,
    input  logic                       i_ext_ready,
    input  logic [1:0]                 i_ext_status,
    input  logic [DATA_WIDTH-1:0]      i_ext_read_data
);

    localparam int STROBE_WIDTH  = DATA_WIDTH / 8;
    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES > 0);

    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? COUNTER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [COUNTER_WIDTH-1:0] COUNTER_MAX = '1;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_BUSY = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    logic [1:0]               state;
    logic [COUNTER_WIDTH-1:0] timeout_counter;
    logic [ADDRESS_WIDTH:0]   start_offset;
    logic [ADDRESS_WIDTH:0]   end_distance;
    logic                     window_hit;
    logic [STROBE_WIDTH-1:0]  write_strobe;

    // Window decode done with one extra bit so the borrow flags an address
    // outside the window; this avoids wrap and keeps the compare free of
    // constant-only expressions when a bound is zero. The low bits of
    // start_offset are directly the window-relative address.
    always_comb begin
        start_offset = {1'b0, i_address} - {1'b0, START_ADDRESS};
        end_distance = {1'b0, END_ADDRESS} - {1'b0, i_address};
        window_hit   = !start_offset[ADDRESS_WIDTH] && !end_distance[ADDRESS_WIDTH];
    end

    assign o_select = i_request && window_hit;

    // Byte strobes are the per-byte OR of the write mask; reads strobe nothing.
    always_comb begin
        write_strobe = '0;
        for (int k = 0; k < STROBE_WIDTH; k++) begin
            write_strobe[k] = rggen_byte_strobe(i_write_mask[8*k +: 8]);
        end
    end

    // Access sequencer: IDLE launches the external request, BUSY waits for
    // the slave (or the timeout), DONE presents the one-cycle response.
    // External-side outputs are only loaded in IDLE so they stay stable in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= STATE_IDLE;
            timeout_counter  <= '0;
            o_ready          <= 1'b0;
            o_status         <= RGGEN_OKAY;
            o_read_data      <= '0;
            o_ext_valid      <= 1'b0;
            o_ext_address    <= '0;
            o_ext_write      <= 1'b0;
            o_ext_write_data <= '0;
            o_ext_strobe     <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (o_select) begin
                        o_ext_valid      <= 1'b1;
                        o_ext_address    <= start_offset[ADDRESS_WIDTH-1:0];
                        o_ext_write      <= (i_write == RGGEN_WRITE);
                        o_ext_write_data <= i_write_data;
                        o_ext_strobe     <= (i_write == RGGEN_WRITE) ? write_strobe : '0;
                        state            <= STATE_BUSY;
                    end
                end
                STATE_BUSY: begin
                    // Ready has priority over a timeout expiring in the same cycle.
                    if (i_ext_ready) begin
                        o_status    <= i_ext_status;
                        o_read_data <= o_ext_write ? '0 : i_ext_read_data;
                        o_ext_valid <= 1'b0;
                        o_ready     <= 1'b1;
                        state       <= STATE_DONE;
                    end else if (TIMEOUT_ENABLED && (timeout_counter == TIMEOUT_LAST)) begin
                        o_status    <= RGGEN_SLAVE_ERROR;
                        o_read_data <= '0;
                        o_ext_valid <= 1'b0;
                        o_ready     <= 1'b1;
                        state       <= STATE_DONE;
                    end else if (timeout_counter != COUNTER_MAX) begin
                        timeout_counter <= timeout_counter + 1'b1;
                    end
                end
                STATE_DONE: begin
                    o_ready         <= 1'b0;
                    o_read_data     <= '0;
                    timeout_counter <= '0;
                    state           <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_external_register.sv
// ---------------------------------------------------------------------------
// tb_rggen_external_register
//
// Purpose: directed self-checking bench for rggen_external_register with a
// window of 0x100..0x1FF, 32-bit data and an 8-cycle timeout.
// ---------------------------------------------------------------------------
module tb_rggen_external_register;

    logic        clk;
    logic        rst_n;
    logic        i_request;
    logic [15:0] i_address;
    logic        i_write;
    logic [31:0] i_write_data;
    logic [31:0] i_write_mask;
    logic        o_select;
    logic        o_ready;
    logic [1:0]  o_status;
    logic [31:0] o_read_data;
    logic        o_ext_valid;
    logic [15:0] o_ext_address;
    logic        o_ext_write;
    logic [31:0] o_ext_write_data;
    logic [3:0]  o_ext_strobe;
    logic        i_ext_ready;
    logic [1:0]  i_ext_status;
    logic [31:0] i_ext_read_data;

    int passed;
    int total;

    // Results captured by run_access for the calling test.
    int          acc_latency;
    int          acc_valid_cycles;
    logic [31:0] acc_read_data;
    logic [1:0]  acc_status;
    logic [15:0] acc_ext_address;
    logic [3:0]  acc_ext_strobe;
    logic [31:0] acc_ext_write_data;
    logic        acc_ext_write;
    logic        acc_ext_valid_c1;

    rggen_external_register #(
        .ADDRESS_WIDTH  (16),
        .START_ADDRESS  (16'h0100),
        .END_ADDRESS    (16'h01FF),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_request        (i_request),
        .i_address        (i_address),
        .i_write          (i_write),
        .i_write_data     (i_write_data),
        .i_write_mask     (i_write_mask),
        .o_select         (o_select),
        .o_ready          (o_ready),
        .o_status         (o_status),
        .o_read_data      (o_read_data),
        .o_ext_valid      (o_ext_valid),
        .o_ext_address    (o_ext_address),
        .o_ext_write      (o_ext_write),
        .o_ext_write_data (o_ext_write_data),
        .o_ext_strobe     (o_ext_strobe),
        .i_ext_ready      (i_ext_ready),
        .i_ext_status     (i_ext_status),
        .i_ext_read_data  (i_ext_read_data)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives a host request; caller is positioned just after a rising edge.
    task applyStimulus(input logic [15:0] addr, input logic wr,
                       input logic [31:0] data, input logic [31:0] mask);
        i_request    = 1'b1;
        i_address    = addr;
        i_write      = wr;
        i_write_data = data;
        i_write_mask = mask;
    endtask

    // Plays the external slave for one access already requested by the host
    // (request cycle = 0). The slave raises ready in cycle ready_cycle
    // (0 = never). Latency is the cycle o_ready is seen, -1 if it never is.
    task run_access(input int ready_cycle, input logic [1:0] slave_status,
                    input logic [31:0] slave_rdata);
        acc_latency      = -1;
        acc_valid_cycles = 0;
        acc_read_data    = 'x;
        acc_status       = 'x;
        acc_ext_valid_c1 = 1'b0;
        i_ext_status     = slave_status;
        i_ext_read_data  = slave_rdata;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                acc_ext_valid_c1   = o_ext_valid;
                acc_ext_address    = o_ext_address;
                acc_ext_strobe     = o_ext_strobe;
                acc_ext_write_data = o_ext_write_data;
                acc_ext_write      = o_ext_write;
            end
            if (o_ext_valid) acc_valid_cycles++;
            if (o_ready) begin
                acc_latency   = cyc;
                acc_read_data = o_read_data;
                acc_status    = o_status;
                break;
            end
            i_ext_ready = (ready_cycle != 0) && (cyc == ready_cycle);
        end
        i_ext_ready = 1'b0;
        i_request   = 1'b0;
    endtask

    task test_reset;
        rst_n        = 1'b0;
        i_request    = 1'b0;
        i_address    = '0;
        i_write      = 1'b0;
        i_write_data = '0;
        i_write_mask = '0;
        i_ext_ready  = 1'b0;
        i_ext_status = '0;
        i_ext_read_data = '0;
        #3;
        total++; if (o_ext_valid !== 1'b0) $display("[TB] FAIL reset_ext_valid got %b want 0", o_ext_valid); else passed++;
        total++; if (o_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", o_ready); else passed++;
        total++; if (o_status !== 2'b00) $display("[TB] FAIL reset_status got %b want 00", o_status); else passed++;
        total++; if (o_read_data !== 32'h0) $display("[TB] FAIL reset_read_data got %h want 0", o_read_data); else passed++;
        total++; if (o_ext_address !== 16'h0) $display("[TB] FAIL reset_ext_address got %h want 0", o_ext_address); else passed++;
        total++; if (o_ext_strobe !== 4'h0) $display("[TB] FAIL reset_ext_strobe got %b want 0", o_ext_strobe); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task test_write;
        applyStimulus(16'h0104, 1'b1, 32'hDEADBEEF, 32'h0000FFFF);
        #1;
        total++; if (o_select !== 1'b1) $display("[TB] FAIL write_select got %b want 1", o_select); else passed++;
        run_access(3, 2'b00, 32'hAAAA5555);
        total++; if (acc_ext_valid_c1 !== 1'b1) $display("[TB] FAIL write_ext_valid got %b want 1", acc_ext_valid_c1); else passed++;
        total++; if (acc_ext_address !== 16'h0004) $display("[TB] FAIL write_ext_address got %h want 0004", acc_ext_address); else passed++;
        total++; if (acc_ext_strobe !== 4'b0011) $display("[TB] FAIL write_strobe got %b want 0011", acc_ext_strobe); else passed++;
        total++; if (acc_ext_write_data !== 32'hDEADBEEF) $display("[TB] FAIL write_ext_data got %h want deadbeef", acc_ext_write_data); else passed++;
        total++; if (acc_ext_write !== 1'b1) $display("[TB] FAIL write_ext_dir got %b want 1", acc_ext_write); else passed++;
        total++; if (acc_latency !== 4) $display("[TB] FAIL write_latency got %0d want 4", acc_latency); else passed++;
        total++; if (acc_status !== 2'b00) $display("[TB] FAIL write_status got %b want 00", acc_status); else passed++;
        total++; if (acc_read_data !== 32'h0) $display("[TB] FAIL write_read_data got %h want 0", acc_read_data); else passed++;
        @(posedge clk);
        #1;
        total++; if (o_ready !== 1'b0) $display("[TB] FAIL write_ready_pulse got %b want 0", o_ready); else passed++;
    endtask

    // Issued in the cycle right after the previous access returns to IDLE.
    task test_back_to_back_read;
        applyStimulus(16'h01FC, 1'b0, 32'h0, 32'hFFFFFFFF);
        run_access(1, 2'b01, 32'h12345678);
        total++; if (acc_latency !== 2) $display("[TB] FAIL read_latency got %0d want 2", acc_latency); else passed++;
        total++; if (acc_read_data !== 32'h12345678) $display("[TB] FAIL read_data got %h want 12345678", acc_read_data); else passed++;
        total++; if (acc_status !== 2'b01) $display("[TB] FAIL read_status got %b want 01", acc_status); else passed++;
        total++; if (acc_ext_strobe !== 4'b0000) $display("[TB] FAIL read_strobe got %b want 0000", acc_ext_strobe); else passed++;
        total++; if (acc_ext_address !== 16'h00FC) $display("[TB] FAIL read_ext_address got %h want 00fc", acc_ext_address); else passed++;
        @(posedge clk);
        #1;
        total++; if (o_read_data !== 32'h0) $display("[TB] FAIL read_data_clear got %h want 0", o_read_data); else passed++;
        total++; if (o_ext_valid !== 1'b0) $display("[TB] FAIL read_no_relaunch got %b want 0", o_ext_valid); else passed++;
    endtask

    task test_timeout;
        logic seen_activity;
        applyStimulus(16'h0120, 1'b0, 32'h0, 32'h0);
        run_access(0, 2'b00, 32'h00000055);
        total++; if (acc_valid_cycles !== 8) $display("[TB] FAIL timeout_valid_cycles got %0d want 8", acc_valid_cycles); else passed++;
        total++; if (acc_latency !== 9) $display("[TB] FAIL timeout_latency got %0d want 9", acc_latency); else passed++;
        total++; if (acc_status !== 2'b10) $display("[TB] FAIL timeout_status got %b want 10", acc_status); else passed++;
        total++; if (acc_read_data !== 32'h0) $display("[TB] FAIL timeout_read_data got %h want 0", acc_read_data); else passed++;
        // Late ready from the slave after the abort must be ignored.
        i_ext_ready   = 1'b1;
        seen_activity = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (o_ready || o_ext_valid) seen_activity = 1'b1;
        end
        i_ext_ready = 1'b0;
        total++; if (seen_activity !== 1'b0) $display("[TB] FAIL timeout_late_ready got %b want 0", seen_activity); else passed++;
    endtask

    task test_coincident_ready;
        applyStimulus(16'h0130, 1'b0, 32'h0, 32'h0);
        run_access(8, 2'b00, 32'hCAFEF00D);
        total++; if (acc_latency !== 9) $display("[TB] FAIL coincident_latency got %0d want 9", acc_latency); else passed++;
        total++; if (acc_status !== 2'b00) $display("[TB] FAIL coincident_status got %b want 00", acc_status); else passed++;
        total++; if (acc_read_data !== 32'hCAFEF00D) $display("[TB] FAIL coincident_read_data got %h want cafef00d", acc_read_data); else passed++;
        @(posedge clk);
        #1;
    endtask

    task test_window;
        logic [15:0] miss_addr [2];
        logic [15:0] edge_addr [2];
        logic        launched;
        miss_addr[0] = 16'h00FF;
        miss_addr[1] = 16'h0200;
        edge_addr[0] = 16'h0100;
        edge_addr[1] = 16'h01FF;
        for (int n = 0; n < 2; n++) begin
            applyStimulus(miss_addr[n], 1'b1, 32'h1, 32'hFFFFFFFF);
            #1;
            total++; if (o_select !== 1'b0) $display("[TB] FAIL window_miss_select addr %h got %b want 0", miss_addr[n], o_select); else passed++;
            launched = 1'b0;
            for (int cyc = 0; cyc < 4; cyc++) begin
                @(posedge clk);
                #1;
                if (o_ext_valid) launched = 1'b1;
            end
            i_request = 1'b0;
            total++; if (launched !== 1'b0) $display("[TB] FAIL window_miss_launch addr %h got %b want 0", miss_addr[n], launched); else passed++;
        end
        for (int n = 0; n < 2; n++) begin
            applyStimulus(edge_addr[n], 1'b0, 32'h0, 32'h0);
            #1;
            total++; if (o_select !== 1'b1) $display("[TB] FAIL window_edge_select addr %h got %b want 1", edge_addr[n], o_select); else passed++;
            i_request = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task test_reset_mid_busy;
        logic saw_ready;
        applyStimulus(16'h0140, 1'b1, 32'h11223344, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        total++; if (o_ext_valid !== 1'b1) $display("[TB] FAIL midreset_busy_valid got %b want 1", o_ext_valid); else passed++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (o_ext_valid !== 1'b0) $display("[TB] FAIL midreset_valid_drop got %b want 0", o_ext_valid); else passed++;
        total++; if (o_ready !== 1'b0) $display("[TB] FAIL midreset_ready got %b want 0", o_ready); else passed++;
        i_request = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        saw_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk);
            #1;
            if (o_ready || o_ext_valid) saw_ready = 1'b1;
        end
        total++; if (saw_ready !== 1'b0) $display("[TB] FAIL midreset_no_response got %b want 0", saw_ready); else passed++;
        applyStimulus(16'h0100, 1'b0, 32'h0, 32'h0);
        run_access(2, 2'b00, 32'h0BADCAFE);
        total++; if (acc_latency !== 3) $display("[TB] FAIL postreset_latency got %0d want 3", acc_latency); else passed++;
        total++; if (acc_read_data !== 32'h0BADCAFE) $display("[TB] FAIL postreset_read_data got %h want 0badcafe", acc_read_data); else passed++;
        total++; if (acc_ext_address !== 16'h0000) $display("[TB] FAIL postreset_ext_address got %h want 0000", acc_ext_address); else passed++;
        @(posedge clk);
        #1;
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_write();
        test_back_to_back_read();
        test_timeout();
        test_coincident_ready();
        test_window();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
